// File: rtl/sensor_capture_ctrl.sv
// Serial sensor frame capture: start detect, mid-bit sampling, MSB-first shift,
// stop check, and valid/ready handoff with sticky framing/overrun flags.
module sensor_capture_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              sensor_in,
    input  logic              data_ready,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);

    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned BIT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, START, SHIFT, STOP} state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync1_d, sync2_q, sync2_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                ferr_q, ferr_d;
    logic                ovr_q, ovr_d;
    logic                sensor_s;
    logic                tick;
    logic                stop_tick;
    logic                load;

    assign sensor_s   = sync2_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sync1_d   = sensor_in;
        sync2_d   = sync1_q;
        cnt_d     = cnt_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = ferr_q;
        ovr_d     = ovr_q;
        tick      = (cnt_q == '0);
        stop_tick = 1'b0;
        load      = 1'b0;

        // Bit timer free-runs with auto-reload while a frame is in progress
        if (state_q != IDLE) begin
            cnt_d = tick ? CNT_FULL : cnt_q - CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (enable && !sensor_s) begin
                    state_d = START;
                    cnt_d   = CNT_HALF;
                end
            end
            START: begin
                if (tick) begin
                    if (!sensor_s) begin
                        state_d  = SHIFT;
                        bitcnt_d = '0;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            SHIFT: begin
                if (tick) begin
                    shreg_d  = {shreg_q[DATA_W-2:0], sensor_s};
                    bitcnt_d = bitcnt_q + BIT_W'(1);
                    if (bitcnt_q == BIT_LAST) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d   = IDLE;
                    stop_tick = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Holding register: a same-cycle accept frees the slot for the new word
        load = stop_tick && sensor_s && (!valid_q || data_ready);
        if (data_ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = shreg_q;
        end

        // Sticky flags: a set in the same cycle as err_clr wins
        if (err_clr) begin
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end
        if (stop_tick && !sensor_s) begin
            ferr_d = 1'b1;
        end
        if (stop_tick && sensor_s && valid_q && !data_ready) begin
            ovr_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_sensor_capture_ctrl.sv
// Bench for sensor_capture_ctrl: frame vector table, corner-case sequences,
// and random frames scored against a frame-level holding-register model.
module tb_sensor_capture_ctrl;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned DIV       = 16;
    localparam int          FRAME_CYC = (DATA_W + 2) * DIV;
    // Edge index (from the first low-driven edge) at which the stop bit is judged
    localparam int          LOAD_CYC  = 2 + DIV / 2 + (DATA_W + 1) * DIV;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              sensor_in;
    logic              data_ready;
    logic              err_clr;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              busy;
    logic              frame_err;
    logic              overrun;

    int n_checks = 0;
    int n_fail   = 0;

    sensor_capture_ctrl #(.DATA_W(DATA_W), .DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .sensor_in  (sensor_in),
        .data_ready (data_ready),
        .err_clr    (err_clr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] word;
        logic              stop;
        logic              rdy;
        logic              clr;
        logic              drain;
        logic [DATA_W-1:0] exp_out;
        logic              exp_valid;
        logic              exp_fe;
        logic              exp_ov;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input logic [DATA_W-1:0] e_out, input logic e_valid,
                            input logic e_fe, input logic e_ov);
        chk({name, " data_out"},   32'(data_out),   32'(e_out));
        chk({name, " data_valid"}, 32'(data_valid), 32'(e_valid));
        chk({name, " busy"},       32'(busy),       32'(1'b0));
        chk({name, " frame_err"},  32'(frame_err),  32'(e_fe));
        chk({name, " overrun"},    32'(overrun),    32'(e_ov));
    endtask

    // Drives start, DATA_W data bits MSB-first and stop, one bit per DIV cycles
    task automatic send_frame(input logic [DATA_W-1:0] word, input logic stop, input logic rdy_at_load,
                              input int en_drop_cyc, input int ncyc,
                              output int busy_rise, output int valid_rise, output int busy_seen);
        logic [DATA_W+1:0] bits;
        logic              prev_valid;
        bits       = {1'b0, word, stop};
        busy_rise  = -1;
        valid_rise = -1;
        busy_seen  = 0;
        prev_valid = data_valid;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge clk);
            if (cyc > 0) begin
                if (busy) busy_seen = 1;
                if (busy && busy_rise < 0) busy_rise = cyc - 1;
                if (data_valid && !prev_valid && valid_rise < 0) valid_rise = cyc - 1;
            end
            prev_valid = data_valid;
            sensor_in  = bits[DATA_W + 1 - cyc / DIV];
            data_ready = rdy_at_load && (cyc == LOAD_CYC);
            if (cyc == en_drop_cyc) enable = 1'b0;
        end
    endtask

    task automatic idle_gap();
        @(negedge clk);
        sensor_in  = 1'b1;
        data_ready = 1'b0;
        repeat (2 * DIV) @(negedge clk);
    endtask

    task automatic pulse_ready();
        @(negedge clk) data_ready = 1'b1;
        @(negedge clk) data_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
    endtask

    initial begin
        int                br, vr, bs, bfall;
        logic [DATA_W-1:0] m_out;
        logic              m_valid, m_fe, m_ov;
        logic              prev_busy;

        tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{8'h55, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; enable = 1'b1; sensor_in = 1'b1; data_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk_outs("reset", '0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].clr) begin
                pulse_clr();
                chk($sformatf("vec%0d clr overrun", i), 32'(overrun), 32'(1'b0));
                chk($sformatf("vec%0d clr frame_err", i), 32'(frame_err), 32'(1'b0));
            end
            send_frame(tbl[i].word, tbl[i].stop, tbl[i].rdy, -1, FRAME_CYC, br, vr, bs);
            idle_gap();
            if (i == 0) begin
                chk("first start entry edge", 32'(br), 32'(2));
                chk("first valid edge", 32'(vr), 32'(LOAD_CYC));
            end
            chk_outs($sformatf("vec%0d", i), tbl[i].exp_out, tbl[i].exp_valid, tbl[i].exp_fe, tbl[i].exp_ov);
            if (tbl[i].drain) begin
                pulse_ready();
                chk($sformatf("vec%0d drain valid", i), 32'(data_valid), 32'(1'b0));
            end
        end
        pulse_clr();
        chk("frame_err clear", 32'(frame_err), 32'(1'b0));

        // Three-cycle glitch: START entered, rejected at the half-bit check
        br = -1; bfall = -1; prev_busy = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (cyc > 0) begin
                if (busy && br < 0) br = cyc - 1;
                if (!busy && prev_busy && bfall < 0) bfall = cyc - 1;
            end
            prev_busy = busy;
            sensor_in = (cyc < 3) ? 1'b0 : 1'b1;
        end
        chk("glitch busy rise", 32'(br), 32'(2));
        chk("glitch busy fall", 32'(bfall), 32'(2 + DIV / 2));
        chk_outs("glitch", 8'h55, 1'b0, 1'b0, 1'b0);

        // enable dropped mid-frame does not abort; later frames are ignored
        send_frame(8'h81, 1'b1, 1'b0, 4 * DIV + DIV / 2, FRAME_CYC, br, vr, bs);
        idle_gap();
        chk_outs("enable drop", 8'h81, 1'b1, 1'b0, 1'b0);
        send_frame(8'h42, 1'b1, 1'b0, -1, FRAME_CYC, br, vr, bs);
        idle_gap();
        chk("disabled busy seen", 32'(bs), 32'(0));
        chk_outs("disabled", 8'h81, 1'b1, 1'b0, 1'b0);
        enable = 1'b1;

        // Asynchronous reset in the middle of data bit 4
        send_frame(8'h81, 1'b1, 1'b0, -1, 5 * DIV + DIV / 2, br, vr, bs);
        chk("pre-reset busy", 32'(busy), 32'(1'b1));
        #2 rst_n = 1'b0;
        #1 chk_outs("async reset", '0, 1'b0, 1'b0, 1'b0);
        sensor_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h81, 1'b1, 1'b0, -1, FRAME_CYC, br, vr, bs);
        idle_gap();
        chk("post-reset valid edge", 32'(vr), 32'(LOAD_CYC));
        chk_outs("post-reset", 8'h81, 1'b1, 1'b0, 1'b0);

        // Random frames against a frame-level model of the holding register
        m_out = 8'h81; m_valid = 1'b1; m_fe = 1'b0; m_ov = 1'b0;
        for (int n = 0; n < 16; n++) begin
            logic [DATA_W-1:0] w;
            logic              stp, rdy, clr, drn;
            w   = DATA_W'($urandom);
            stp = ($urandom_range(0, 7) != 0);
            rdy = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 2) == 0);
            drn = ($urandom_range(0, 1) == 1);
            if (clr) begin
                pulse_clr();
                m_fe = 1'b0;
                m_ov = 1'b0;
            end
            send_frame(w, stp, rdy, -1, FRAME_CYC, br, vr, bs);
            idle_gap();
            if (rdy) m_valid = 1'b0;
            if (!stp) begin
                m_fe = 1'b1;
            end else if (m_valid) begin
                m_ov = 1'b1;
            end else begin
                m_out   = w;
                m_valid = 1'b1;
            end
            chk_outs($sformatf("rand%0d w=%0h stop=%0b rdy=%0b", n, w, stp, rdy), m_out, m_valid, m_fe, m_ov);
            if (drn) begin
                pulse_ready();
                m_valid = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
